// File: rtl/tthbif_cfg_ctrl.sv
// UART-driven config controller: byte command parser, per-lane tap registers.
// Optional drop counter at address 4'hE enabled by TTHBIF_CFG_DROPCNT_EN.
module tthbif_cfg_ctrl #(
  parameter int NUM_LANES      = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   rx_data_valid_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   tx_data_ready_i,
  output logic                   tx_data_valid_o,
  output logic [7:0]             tx_data_o,
  output logic [2*NUM_LANES-1:0] comb_tap_sel_o,
  output logic [2*NUM_LANES-1:0] flop_tap_sel_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_lane [NUM_LANES];
  logic [3:0]      r_addr;
  logic [CW-1:0]   r_cnt;
  logic            r_tx_valid;
  logic [7:0]      r_tx_data;
  logic [7:0]      w_rd_data;
  logic            w_strobe;
  logic            w_last;
  logic            w_unused;

  assign w_strobe = rx_data_valid_i & en_i;
  assign w_last   = (r_cnt == TO_LAST);
  assign w_unused = ^rx_data_i[6:4];

`ifdef TTHBIF_CFG_DROPCNT_EN
  logic [7:0] r_drop;
  logic       w_drop_inc;
  logic       w_drop_clr;

  assign w_drop_inc =
    (rx_data_valid_i & (~en_i | (r_state == S_RESP))) |
    ((r_state == S_WAIT) & en_i & ~rx_data_valid_i & w_last);
  assign w_drop_clr = (r_state == S_WAIT) & w_strobe & (r_addr == 4'hE);

  // Saturating count of dropped bytes and abandoned writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_drop <= 8'h00;
    end else if (w_drop_clr) begin
      r_drop <= 8'h00;
    end else if (w_drop_inc && r_drop != 8'hFF) begin
      r_drop <= r_drop + 8'h01;
    end
  end
`endif

  // Read mux addressed by the incoming CMD byte
  always_comb begin
    w_rd_data = 8'h00;
    if (rx_data_i[3:0] == 4'hF) begin
      w_rd_data = 8'hA5;
    end
`ifdef TTHBIF_CFG_DROPCNT_EN
    if (rx_data_i[3:0] == 4'hE) begin
      w_rd_data = r_drop;
    end
`endif
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rx_data_i[3:0] == 4'(i)) begin
        w_rd_data = {4'h0, r_lane[i]};
      end
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a DATA strobe beats a same-cycle timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_strobe) begin
          w_next = rx_data_i[7] ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (!en_i) begin
          w_next = S_IDLE;
        end else if (rx_data_valid_i) begin
          w_next = S_RESP;
        end else if (w_last) begin
          w_next = S_IDLE;
        end
      end
      S_RESP: begin
        if (tx_data_ready_i) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: address latch, timeout counter, lane writes, response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        r_lane[i] <= 4'hF;
      end
      r_addr     <= 4'h0;
      r_cnt      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_valid <= (w_next == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (w_strobe) begin
            r_addr <= rx_data_i[3:0];
            r_cnt  <= '0;
            if (!rx_data_i[7]) begin
              r_tx_data <= w_rd_data;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_strobe) begin
            for (int i = 0; i < NUM_LANES; i++) begin
              if (r_addr == 4'(i)) begin
                r_lane[i] <= rx_data_i[3:0];
              end
            end
            r_tx_data <= 8'h06;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_data_valid_o = r_tx_valid;
  assign tx_data_o       = r_tx_data;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign comb_tap_sel_o[2*g +: 2] = r_lane[g][1:0];
    assign flop_tap_sel_o[2*g +: 2] = r_lane[g][3:2];
  end

endmodule

// File: tb/tb_tthbif_cfg_ctrl.sv
// Directed bench for tthbif_cfg_ctrl: two lanes, 16-cycle write timeout.
// Drop-counter expectations follow TTHBIF_CFG_DROPCNT_EN.
module tb_tthbif_cfg_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b1;
  logic       rx_data_valid_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       tx_data_ready_i = 1'b1;
  logic       tx_data_valid_o;
  logic [7:0] tx_data_o;
  logic [3:0] comb_tap_sel_o;
  logic [3:0] flop_tap_sel_o;

  int total = 0;
  int bad = 0;
  int xfers = 0;

  tthbif_cfg_ctrl #(
    .NUM_LANES(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i(en_i),
    .rx_data_valid_i(rx_data_valid_i),
    .rx_data_i(rx_data_i),
    .tx_data_ready_i(tx_data_ready_i),
    .tx_data_valid_o(tx_data_valid_o),
    .tx_data_o(tx_data_o),
    .comb_tap_sel_o(comb_tap_sel_o),
    .flop_tap_sel_o(flop_tap_sel_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (!rst_i && tx_data_valid_o && tx_data_ready_i) xfers++;
  end

  // one-cycle rx strobe, called and returning at a negedge
  task automatic strobe(input logic [7:0] b);
    rx_data_valid_i = 1'b1;
    rx_data_i = b;
    @(negedge clk_i);
    rx_data_valid_i = 1'b0;
    rx_data_i = 8'h00;
  endtask

  task automatic do_rd(input logic [7:0] cmd, output logic v, output logic [7:0] d);
    tx_data_ready_i = 1'b1;
    strobe(cmd);
    v = tx_data_valid_o;
    d = tx_data_o;
    @(negedge clk_i);
  endtask

  task automatic do_wr(input logic [7:0] cmd, input logic [7:0] dat,
                       output logic v, output logic [7:0] d);
    tx_data_ready_i = 1'b1;
    strobe(cmd);
    strobe(dat);
    v = tx_data_valid_o;
    d = tx_data_o;
    @(negedge clk_i);
  endtask

  task automatic test_reset;
    logic v;
    logic [7:0] d;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    total++;
    if (tx_data_valid_o !== 1'b0 || tx_data_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_tx got v=%b d=%h exp v=0 d=00", tx_data_valid_o, tx_data_o);
    end
    total++;
    if (comb_tap_sel_o !== 4'hF || flop_tap_sel_o !== 4'hF) begin
      bad++;
      $display("FAIL reset_taps got c=%h f=%h exp F F", comb_tap_sel_o, flop_tap_sel_o);
    end
    do_rd(8'h00, v, d);
    total++;
    if (v !== 1'b1 || d !== 8'h0F) begin
      bad++;
      $display("FAIL reset_read got v=%b d=%h exp v=1 d=0F", v, d);
    end
    total++;
    if (tx_data_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_read_drop got v=%b exp 0", tx_data_valid_o);
    end
  endtask

  task automatic test_write_lane0;
    logic v;
    logic [7:0] d;
    tx_data_ready_i = 1'b1;
    strobe(8'h80);
    total++;
    if (tx_data_valid_o !== 1'b0 || comb_tap_sel_o !== 4'hF) begin
      bad++;
      $display("FAIL wr_cmd_only got v=%b c=%h exp v=0 c=F", tx_data_valid_o, comb_tap_sel_o);
    end
    strobe(8'hF6);
    total++;
    if (comb_tap_sel_o !== 4'b1110 || flop_tap_sel_o !== 4'b1101) begin
      bad++;
      $display("FAIL wr_taps got c=%b f=%b exp 1110 1101", comb_tap_sel_o, flop_tap_sel_o);
    end
    total++;
    if (tx_data_valid_o !== 1'b1 || tx_data_o !== 8'h06) begin
      bad++;
      $display("FAIL wr_ack got v=%b d=%h exp v=1 d=06", tx_data_valid_o, tx_data_o);
    end
    @(negedge clk_i);
    do_rd(8'h00, v, d);
    total++;
    if (v !== 1'b1 || d !== 8'h06) begin
      bad++;
      $display("FAIL wr_readback got v=%b d=%h exp v=1 d=06", v, d);
    end
  endtask

  task automatic test_id_backpressure;
    int x0;
    int stable_bad;
    stable_bad = 0;
    x0 = xfers;
    tx_data_ready_i = 1'b0;
    strobe(8'h0F);
    for (int i = 0; i < 10; i++) begin
      if (tx_data_valid_o !== 1'b1 || tx_data_o !== 8'hA5) stable_bad++;
      @(negedge clk_i);
    end
    total++;
    if (stable_bad != 0) begin
      bad++;
      $display("FAIL id_hold got %0d unstable cycles exp 0 (v=%b d=%h)",
               stable_bad, tx_data_valid_o, tx_data_o);
    end
    tx_data_ready_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (tx_data_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL id_release got v=%b exp 0", tx_data_valid_o);
    end
    @(negedge clk_i);
    total++;
    if (xfers - x0 != 1) begin
      bad++;
      $display("FAIL id_xfers got %0d exp 1", xfers - x0);
    end
  endtask

  task automatic test_drops;
    logic v;
    logic [7:0] d;
    int x0;
`ifdef TTHBIF_CFG_DROPCNT_EN
    do_wr(8'h8E, 8'h00, v, d);
`endif
    x0 = xfers;
    tx_data_ready_i = 1'b0;
    strobe(8'h00);
    repeat (3) strobe(8'h80);
    total++;
    if (tx_data_valid_o !== 1'b1 || tx_data_o !== 8'h06) begin
      bad++;
      $display("FAIL drop_resp got v=%b d=%h exp v=1 d=06", tx_data_valid_o, tx_data_o);
    end
    tx_data_ready_i = 1'b1;
    @(negedge clk_i);
    en_i = 1'b0;
    strobe(8'h0F);
    en_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (xfers - x0 != 1 || tx_data_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL drop_single got xfers=%0d v=%b exp 1 0", xfers - x0, tx_data_valid_o);
    end
    total++;
    if (comb_tap_sel_o !== 4'b1110 || flop_tap_sel_o !== 4'b1101) begin
      bad++;
      $display("FAIL drop_taps got c=%b f=%b exp 1110 1101", comb_tap_sel_o, flop_tap_sel_o);
    end
    do_rd(8'h0E, v, d);
`ifdef TTHBIF_CFG_DROPCNT_EN
    total++;
    if (v !== 1'b1 || d !== 8'h04) begin
      bad++;
      $display("FAIL dropcnt_read got v=%b d=%h exp v=1 d=04", v, d);
    end
    do_wr(8'h8E, 8'h00, v, d);
    total++;
    if (v !== 1'b1 || d !== 8'h06) begin
      bad++;
      $display("FAIL dropcnt_clr_ack got v=%b d=%h exp v=1 d=06", v, d);
    end
    do_rd(8'h0E, v, d);
    total++;
    if (v !== 1'b1 || d !== 8'h00) begin
      bad++;
      $display("FAIL dropcnt_reread got v=%b d=%h exp v=1 d=00", v, d);
    end
`else
    total++;
    if (v !== 1'b1 || d !== 8'h00) begin
      bad++;
      $display("FAIL addr_e_unmapped got v=%b d=%h exp v=1 d=00", v, d);
    end
`endif
  endtask

  task automatic test_timeout;
    logic v;
    logic [7:0] d;
    int seen;
    seen = 0;
    tx_data_ready_i = 1'b1;
    strobe(8'h81);
    for (int i = 0; i < 16; i++) begin
      if (tx_data_valid_o !== 1'b0) seen++;
      @(negedge clk_i);
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL tmo_silent got %0d valid cycles exp 0", seen);
    end
    do_rd(8'h0F, v, d);
    total++;
    if (v !== 1'b1 || d !== 8'hA5) begin
      bad++;
      $display("FAIL tmo_idle_read got v=%b d=%h exp v=1 d=A5", v, d);
    end
    total++;
    if (comb_tap_sel_o !== 4'b1110 || flop_tap_sel_o !== 4'b1101) begin
      bad++;
      $display("FAIL tmo_taps got c=%b f=%b exp 1110 1101", comb_tap_sel_o, flop_tap_sel_o);
    end
`ifdef TTHBIF_CFG_DROPCNT_EN
    do_rd(8'h0E, v, d);
    total++;
    if (d !== 8'h01) begin
      bad++;
      $display("FAIL tmo_dropcnt got %h exp 01", d);
    end
`endif
  endtask

  task automatic test_timeout_edge;
    tx_data_ready_i = 1'b1;
    strobe(8'h81);
    repeat (15) @(negedge clk_i);
    strobe(8'h09);
    total++;
    if (tx_data_valid_o !== 1'b1 || tx_data_o !== 8'h06) begin
      bad++;
      $display("FAIL tmo_edge_ack got v=%b d=%h exp v=1 d=06", tx_data_valid_o, tx_data_o);
    end
    total++;
    if (comb_tap_sel_o !== 4'b0110 || flop_tap_sel_o !== 4'b1001) begin
      bad++;
      $display("FAIL tmo_edge_taps got c=%b f=%b exp 0110 1001", comb_tap_sel_o, flop_tap_sel_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_en_abort_unmapped;
    logic v;
    logic [7:0] d;
    tx_data_ready_i = 1'b1;
    strobe(8'h80);
    en_i = 1'b0;
    @(negedge clk_i);
    en_i = 1'b1;
    do_rd(8'h01, v, d);
    total++;
    if (v !== 1'b1 || d !== 8'h09) begin
      bad++;
      $display("FAIL en_abort_read got v=%b d=%h exp v=1 d=09", v, d);
    end
    do_wr(8'h85, 8'hFF, v, d);
    total++;
    if (v !== 1'b1 || d !== 8'h06 || comb_tap_sel_o !== 4'b0110) begin
      bad++;
      $display("FAIL unmapped_wr got v=%b d=%h c=%b exp 1 06 0110", v, d, comb_tap_sel_o);
    end
    do_rd(8'h05, v, d);
    total++;
    if (v !== 1'b1 || d !== 8'h00) begin
      bad++;
      $display("FAIL unmapped_rd got v=%b d=%h exp v=1 d=00", v, d);
    end
  endtask

  task automatic test_reset_mid;
    logic v;
    logic [7:0] d;
    tx_data_ready_i = 1'b0;
    strobe(8'h0F);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    total++;
    if (tx_data_valid_o !== 1'b0 || tx_data_o !== 8'h00) begin
      bad++;
      $display("FAIL rst_resp got v=%b d=%h exp v=0 d=00", tx_data_valid_o, tx_data_o);
    end
    tx_data_ready_i = 1'b1;
    strobe(8'h80);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    do_rd(8'h00, v, d);
    total++;
    if (v !== 1'b1 || d !== 8'h0F) begin
      bad++;
      $display("FAIL rst_mid_wr got v=%b d=%h exp v=1 d=0F", v, d);
    end
    total++;
    if (comb_tap_sel_o !== 4'hF || flop_tap_sel_o !== 4'hF) begin
      bad++;
      $display("FAIL rst_mid_taps got c=%h f=%h exp F F", comb_tap_sel_o, flop_tap_sel_o);
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_write_lane0();
    test_id_backpressure();
    test_drops();
    test_timeout();
    test_timeout_edge();
    test_en_abort_unmapped();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
